// File: rtl/ordena_n_pipe.sv
// ordena_n_pipe: streaming odd-even transposition sorter, one register stage per exchange layer.
// Each vector carries its own valid, ena and direction bits through the pipeline.
`default_nettype none

module ordena_n_pipe #(
  parameter int LARGURA = 8,
  parameter int N       = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ena,
  input  logic                     cresc_ou_decres,
  input  logic [N*LARGURA-1:0]     dados_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*LARGURA-1:0]     dados_out,
  output logic [LARGURA-1:0]       mediana,
  output logic [$clog2(N+1)-1:0]   ocupacao
);

  localparam int CW = $clog2(N+1);

  typedef logic [N-1:0][LARGURA-1:0] vec_t;

  vec_t         dat [1:N];
  logic [N:1]   vld;
  logic [N-1:1] en;
  logic [N-1:1] up;

  logic adv;
  logic accept;
  logic leave;

  // Layer k pairs (i, i+1) with i even on odd k and i odd on even k; equal values stay put.
  function automatic vec_t layer(input vec_t d, input int k, input logic e, input logic asc);
    vec_t r;
    r = d;
    for (int i = 0; i < N - 1; i++) begin
      if (((i % 2) == ((k - 1) % 2)) && e &&
          (asc ? (d[i] > d[i+1]) : (d[i] < d[i+1]))) begin
        r[i]   = d[i+1];
        r[i+1] = d[i];
      end
    end
    return r;
  endfunction

  assign adv      = !vld[N] || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign leave    = vld[N] && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= N; k++) dat[k] <= '0;
      vld <= '0;
      en  <= '0;
      up  <= '0;
    end else if (adv) begin
      dat[1] <= layer(vec_t'(dados_in), 1, ena, cresc_ou_decres);
      vld[1] <= in_valid;
      en[1]  <= ena;
      up[1]  <= cresc_ou_decres;
      for (int k = 2; k <= N; k++) begin
        dat[k] <= layer(dat[k-1], k, en[k-1], up[k-1]);
        vld[k] <= vld[k-1];
      end
      for (int k = 2; k < N; k++) begin
        en[k] <= en[k-1];
        up[k] <= up[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocupacao <= '0;
    end else if (accept && !leave) begin
      ocupacao <= ocupacao + CW'(1);
    end else if (leave && !accept) begin
      ocupacao <= ocupacao - CW'(1);
    end
  end

  assign out_valid = vld[N];
  assign dados_out = dat[N];
  assign mediana   = dat[N][(N-1)/2];

endmodule

`default_nettype wire

// File: tb/tb_ordena_n_pipe.sv
// Scoreboard bench for ordena_n_pipe: the driver queues expected results at accept time,
// an independent monitor pops and compares on every output transfer.
`timescale 1ns/1ps
`default_nettype none

module tb_ordena_n_pipe;

  localparam int L = 8;
  localparam int N = 9;

  typedef logic [N-1:0][L-1:0] vec_t;
  typedef struct {
    vec_t       data;
    logic [L-1:0] med;
    int         cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ena = 1'b1;
  logic             cresc_ou_decres = 1'b1;
  logic [N*L-1:0]   dados_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N*L-1:0]   dados_out;
  logic [L-1:0]     mediana;
  logic [$clog2(N+1)-1:0] ocupacao;

  ordena_n_pipe #(.LARGURA(L), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ena(ena),
    .cresc_ou_decres(cresc_ou_decres), .dados_in(dados_in), .out_valid(out_valid),
    .out_ready(out_ready), .dados_out(dados_out), .mediana(mediana), .ocupacao(ocupacao)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_out = 0;
  logic strict = 1'b1;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [N*L-1:0] act, input logic [N*L-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int a6, input int a7, input int a8);
    vec_t v;
    v[0] = a0[7:0]; v[1] = a1[7:0]; v[2] = a2[7:0]; v[3] = a3[7:0]; v[4] = a4[7:0];
    v[5] = a5[7:0]; v[6] = a6[7:0]; v[7] = a7[7:0]; v[8] = a8[7:0];
    return v;
  endfunction

  // Reference: selection sort on a copy, choosing the extreme with the lowest index.
  function automatic vec_t ref_sort(input vec_t v, input logic e, input logic asc);
    vec_t r;
    logic [L-1:0] t;
    int b;
    r = v;
    if (e) begin
      for (int i = 0; i < N; i++) begin
        b = i;
        for (int j = i + 1; j < N; j++)
          if (asc ? (r[j] < r[b]) : (r[j] > r[b])) b = j;
        t = r[b]; r[b] = r[i]; r[i] = t;
      end
    end
    return r;
  endfunction

  task automatic send(input vec_t v, input logic e, input logic d, input vec_t ex);
    int   w;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    dados_in = v;
    ena = e;
    cresc_ou_decres = d;
    #1;
    w = 0;
    while (!in_ready) begin
      w++;
      if (w > 50) begin
        total++; bad++;
        $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
        return;
      end
      @(negedge clk);
      #1;
    end
    x.data = ex;
    x.med  = ex[(N-1)/2];
    x.cyc  = cyc + N;
    q.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      #3;
      w++;
    end
    chk({nm, "_drained"}, N*L'(q.size()), '0);
  endtask

  task automatic send_rand(input logic d);
    vec_t v;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i] = 8'd0;
        1:       v[i] = 8'd255;
        default: v[i] = 8'($urandom_range(0, 255));
      endcase
    end
    send(v, 1'b1, d, ref_sort(v, 1'b1, d));
  endtask

  // Monitor: compares on every accepted output, independent of the stimulus process.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", dados_out, '0);
      end else begin
        e = q.pop_front();
        chk("dados_out", dados_out, e.data);
        chk("mediana", N*L'(mediana), N*L'(e.med));
        if (strict) chk("latency_cycle", N*L'(cyc), N*L'(e.cyc));
        n_out++;
      end
    end
  end

  vec_t v1, v2;
  vec_t held;
  logic [L-1:0] held_m;
  int   n_before;
  int   w;

  initial begin
    v1 = mk(9, 8, 7, 6, 5, 4, 3, 2, 1);
    v2 = mk(3, 7, 7, 0, 255, 1, 128, 7, 2);

    // Reset state, with out_ready low to show in_ready comes from the empty pipeline.
    #2;
    chk("rst_out_valid", N*L'(out_valid), '0);
    chk("rst_dados_out", dados_out, '0);
    chk("rst_mediana", N*L'(mediana), '0);
    chk("rst_ocupacao", N*L'(ocupacao), '0);
    chk("rst_in_ready", N*L'(in_ready), N*L'(1));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // 1: ascending, reversed input
    send(v1, 1'b1, 1'b1, mk(1, 2, 3, 4, 5, 6, 7, 8, 9));
    idle();
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      #3;
      w++;
    end
    chk("t1_out_valid", N*L'(out_valid), N*L'(1));
    chk("t1_ocupacao", N*L'(ocupacao), N*L'(1));
    chk("t1_mediana", N*L'(mediana), N*L'(5));
    drain("t1");

    // 2: descending with duplicates and extremes; 3: pass-through
    send(v2, 1'b1, 1'b0, mk(255, 128, 7, 7, 7, 3, 2, 1, 0));
    send(v2, 1'b0, 1'b1, v2);
    idle();
    drain("t23");

    // 4: back-to-back stream with direction toggling
    for (int v = 0; v < 20; v++) begin
      send_rand(v[0]);
      if (v == 12) begin
        #2;
        chk("t4_ocupacao_full", N*L'(ocupacao), N*L'(9));
      end
    end
    idle();
    drain("t4");

    // 5: backpressure mid-stream
    strict = 1'b0;
    n_before = n_out;
    fork
      begin
        for (int v = 0; v < 20; v++) send_rand(v[0]);
        idle();
      end
      begin
        repeat (12) @(negedge clk);
        out_ready = 1'b0;
        #3;
        held   = dados_out;
        held_m = mediana;
        for (int c = 0; c < 5; c++) begin
          if (c > 0) begin
            @(negedge clk);
            #3;
          end
          chk("t5_in_ready_stall", N*L'(in_ready), '0);
          chk("t5_out_valid_stall", N*L'(out_valid), N*L'(1));
          chk("t5_dados_held", dados_out, held);
          chk("t5_mediana_held", N*L'(mediana), N*L'(held_m));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("t5");
    chk("t5_result_count", N*L'(n_out - n_before), N*L'(20));
    strict = 1'b1;

    // 6: reset with five vectors in flight
    for (int v = 0; v < 5; v++) send_rand(1'b1);
    idle();
    #1;
    chk("t6_ocupacao_before", N*L'(ocupacao), N*L'(5));
    #3;
    out_ready = 1'b0;
    rst = 1'b1;
    q.delete();
    #1;
    chk("t6_out_valid_rst", N*L'(out_valid), '0);
    chk("t6_ocupacao_rst", N*L'(ocupacao), '0);
    chk("t6_in_ready_rst", N*L'(in_ready), N*L'(1));
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(v1, 1'b1, 1'b1, mk(1, 2, 3, 4, 5, 6, 7, 8, 9));
    idle();
    drain("t6");
    repeat (3) @(negedge clk);
    #3;
    chk("t6_ocupacao_end", N*L'(ocupacao), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
